// File: rtl/mem_access_stage.sv
// Memory-access stage of the multicycle MIPS datapath.
//
// Takes the ALU result as the effective address and register read data 2 as
// store data, runs byte/half/word loads and stores against a variable-latency
// data memory over a req/ack handshake, and holds busy high while the access
// is in flight. Load data is lane-selected and sign- or zero-extended.
//
// Ports:
//   clock, reset     rising-edge clock, synchronous active-high reset
//   start            one-cycle operation request, sampled only in idle
//   mem_read         operation is a load
//   mem_write        operation is a store (wins over mem_read)
//   size             00 byte, 01 half, 10/11 word
//   load_unsigned    1 = zero-extend load data, 0 = sign-extend
//   address          effective address
//   write_data       store data
//   busy             high while not idle
//   done             one-cycle completion pulse
//   read_data        formatted load result, held until the next load completes
//   misaligned       pulses with done when the address was rejected
//   timeout          pulses with done when the memory never acknowledged
//   dm_req, dm_we    data-memory request and write enable
//   dm_addr          word-aligned address
//   dm_wdata         lane-replicated store data
//   dm_be            byte enables, bit i covers bits 8i+7..8i
//   dm_rdata, dm_ack data-memory read data and acknowledge
module mem_access_stage #(
  parameter int unsigned WAIT_LIMIT = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  size,
  input  logic        load_unsigned,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] read_data,
  output logic        misaligned,
  output logic        timeout,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic [3:0]  dm_be,
  input  logic [31:0] dm_rdata,
  input  logic        dm_ack
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StReq  = 2'd1;
  localparam logic [1:0] StFin  = 2'd2;

  // Last counter value before the access is abandoned.
  localparam logic [15:0] CntMax = 16'(WAIT_LIMIT - 1);

  logic [1:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        is_write_q, is_write_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [1:0]  lane_q, lane_d;

  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        mis_q, mis_d;
  logic        to_q, to_d;
  logic [31:0] read_data_q, read_data_d;
  logic        dm_req_q, dm_req_d;
  logic        dm_we_q, dm_we_d;
  logic [31:0] dm_addr_q, dm_addr_d;
  logic [31:0] dm_wdata_q, dm_wdata_d;
  logic [3:0]  dm_be_q, dm_be_d;

  // Request decode on the incoming operation.
  logic        is_access;
  logic        addr_bad;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc;

  always_comb begin
    is_access = mem_read | mem_write;
    addr_bad  = 1'b0;
    be_calc   = 4'b1111;
    wdata_calc = write_data;
    if (size == 2'b00) begin
      be_calc    = 4'b0001 << address[1:0];
      wdata_calc = {4{write_data[7:0]}};
    end else if (size == 2'b01) begin
      addr_bad   = address[0];
      be_calc    = address[1] ? 4'b1100 : 4'b0011;
      wdata_calc = {2{write_data[15:0]}};
    end else begin
      addr_bad   = (address[1:0] != 2'b00);
    end
  end

  // Load formatting from the latched size, lane and extension mode.
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_fmt;

  always_comb begin
    case (lane_q)
      2'd0:    ld_byte = dm_rdata[7:0];
      2'd1:    ld_byte = dm_rdata[15:8];
      2'd2:    ld_byte = dm_rdata[23:16];
      default: ld_byte = dm_rdata[31:24];
    endcase
    ld_half = lane_q[1] ? dm_rdata[31:16] : dm_rdata[15:0];
    if (size_q == 2'b00) begin
      ld_fmt = uns_q ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
    end else if (size_q == 2'b01) begin
      ld_fmt = uns_q ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
    end else begin
      ld_fmt = dm_rdata;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    is_write_d  = is_write_q;
    size_d      = size_q;
    uns_d       = uns_q;
    lane_d      = lane_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    mis_d       = 1'b0;
    to_d        = 1'b0;
    read_data_d = read_data_q;
    dm_req_d    = dm_req_q;
    dm_we_d     = dm_we_q;
    dm_addr_d   = dm_addr_q;
    dm_wdata_d  = dm_wdata_q;
    dm_be_d     = dm_be_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          busy_d = 1'b1;
          if (!is_access) begin
            state_d = StFin;
            done_d  = 1'b1;
          end else if (addr_bad) begin
            state_d = StFin;
            done_d  = 1'b1;
            mis_d   = 1'b1;
          end else begin
            state_d    = StReq;
            cnt_d      = 16'd0;
            is_write_d = mem_write;
            size_d     = size;
            uns_d      = load_unsigned;
            lane_d     = address[1:0];
            dm_req_d   = 1'b1;
            dm_we_d    = mem_write;
            dm_addr_d  = {address[31:2], 2'b00};
            dm_wdata_d = wdata_calc;
            dm_be_d    = be_calc;
          end
        end
      end
      StReq: begin
        // Ack takes priority over the wait limit in the same cycle.
        if (dm_ack) begin
          state_d  = StFin;
          done_d   = 1'b1;
          dm_req_d = 1'b0;
          dm_we_d  = 1'b0;
          if (!is_write_q) begin
            read_data_d = ld_fmt;
          end
        end else if (cnt_q == CntMax) begin
          state_d  = StFin;
          done_d   = 1'b1;
          to_d     = 1'b1;
          dm_req_d = 1'b0;
          dm_we_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StFin: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
      default: begin
        state_d  = StIdle;
        busy_d   = 1'b0;
        dm_req_d = 1'b0;
        dm_we_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= 16'd0;
      is_write_q  <= 1'b0;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      lane_q      <= 2'b00;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mis_q       <= 1'b0;
      to_q        <= 1'b0;
      read_data_q <= 32'd0;
      dm_req_q    <= 1'b0;
      dm_we_q     <= 1'b0;
      dm_addr_q   <= 32'd0;
      dm_wdata_q  <= 32'd0;
      dm_be_q     <= 4'b0000;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      is_write_q  <= is_write_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      lane_q      <= lane_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      mis_q       <= mis_d;
      to_q        <= to_d;
      read_data_q <= read_data_d;
      dm_req_q    <= dm_req_d;
      dm_we_q     <= dm_we_d;
      dm_addr_q   <= dm_addr_d;
      dm_wdata_q  <= dm_wdata_d;
      dm_be_q     <= dm_be_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign misaligned = mis_q;
  assign timeout    = to_q;
  assign read_data  = read_data_q;
  assign dm_req     = dm_req_q;
  assign dm_we      = dm_we_q;
  assign dm_addr    = dm_addr_q;
  assign dm_wdata   = dm_wdata_q;
  assign dm_be      = dm_be_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage with WAIT_LIMIT=4.
module tb_mem_access_stage;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        load_unsigned = 1'b0;
  logic [31:0] address = 32'd0;
  logic [31:0] write_data = 32'd0;
  logic        busy, done, misaligned, timeout;
  logic [31:0] read_data;
  logic        dm_req, dm_we;
  logic [31:0] dm_addr, dm_wdata;
  logic [3:0]  dm_be;
  logic [31:0] dm_rdata = 32'd0;
  logic        dm_ack = 1'b0;

  always #5 clock = ~clock;

  mem_access_stage #(.WAIT_LIMIT(4)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .size         (size),
    .load_unsigned(load_unsigned),
    .address      (address),
    .write_data   (write_data),
    .busy         (busy),
    .done         (done),
    .read_data    (read_data),
    .misaligned   (misaligned),
    .timeout      (timeout),
    .dm_req       (dm_req),
    .dm_we        (dm_we),
    .dm_addr      (dm_addr),
    .dm_wdata     (dm_wdata),
    .dm_be        (dm_be),
    .dm_rdata     (dm_rdata),
    .dm_ack       (dm_ack)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_t;

  typedef struct {
    logic        mis;
    logic        to;
    logic [31:0] rd;
    int          req;
    int          lat;
    int          issue;
  } done_t;

  bus_t  exp_bus[$];
  done_t exp_done[$];

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int done_count = 0;

  int          ack_delay = -1;
  logic [31:0] rdata_cfg = 32'd0;
  logic        stray_ack = 1'b0;
  int          req_idx = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endfunction

  function automatic void fail(input string name, input string what);
    n_total++;
    $display("FAIL %s: %s", name, what);
  endfunction

  always @(posedge clock) cyc <= cyc + 1;

  // Memory responder: ack after ack_delay full request cycles (-1 = never).
  always @(negedge clock) begin
    if (dm_req) begin
      dm_ack   = (req_idx == ack_delay);
      dm_rdata = dm_ack ? rdata_cfg : 32'hA5A5_A5A5;
      req_idx++;
    end else begin
      dm_ack   = stray_ack;
      dm_rdata = 32'h5A5A_5A5A;
      req_idx  = 0;
    end
  end

  // Monitor.
  logic        req_prev = 1'b0;
  logic        done_prev = 1'b0;
  logic        unstable = 1'b0;
  int          req_len = 0;
  int          busy_len = 0;
  bus_t        snap;

  always @(negedge clock) begin
    bus_t  eb;
    done_t ed;
    if (reset) begin
      req_len   = 0;
      busy_len  = 0;
      req_prev  = 1'b0;
      done_prev = 1'b0;
    end else begin
      busy_len = busy ? busy_len + 1 : 0;
      if (dm_req && !req_prev) begin
        req_len  = 1;
        unstable = 1'b0;
        snap     = '{dm_we, dm_addr, dm_be, dm_wdata};
        if (exp_bus.size() == 0) begin
          fail("unexpected_dm_req", $sformatf("got dm_addr=%h, required no request", dm_addr));
        end else begin
          eb = exp_bus.pop_front();
          check("dm_we", 32'(dm_we), 32'(eb.we));
          check("dm_addr", dm_addr, eb.addr);
          check("dm_be", 32'(dm_be), 32'(eb.be));
          check("dm_wdata", dm_wdata, eb.wdata);
        end
      end else if (dm_req) begin
        req_len++;
        if (dm_we !== snap.we || dm_addr !== snap.addr || dm_be !== snap.be ||
            dm_wdata !== snap.wdata) unstable = 1'b1;
      end
      if (!done && (misaligned || timeout)) begin
        fail("stray_flag", $sformatf("got misaligned=%b timeout=%b without done, required 0",
                                     misaligned, timeout));
      end
      if (done) begin
        done_count++;
        check("done_width", 32'(done_prev), 32'd0);
        if (exp_done.size() == 0) begin
          fail("unexpected_done", "got done=1, required no pending operation");
        end else begin
          ed = exp_done.pop_front();
          check("misaligned", 32'(misaligned), 32'(ed.mis));
          check("timeout", 32'(timeout), 32'(ed.to));
          check("read_data", read_data, ed.rd);
          check("latency", 32'(cyc - ed.issue), 32'(ed.lat));
          check("busy_cycles", 32'(busy_len), 32'(ed.lat));
          check("req_cycles", 32'(req_len), 32'(ed.req));
          if (ed.req > 0) check("bus_stable", 32'(unstable), 32'd0);
        end
        req_len = 0;
      end
      req_prev  = dm_req;
      done_prev = done;
    end
  end

  task automatic start_op(input logic rd, input logic wr, input logic [1:0] sz,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                          input int k, input logic [31:0] rdat,
                          input logic has_bus, input logic [31:0] e_addr,
                          input logic [3:0] e_be, input logic [31:0] e_wd,
                          input logic has_done, input logic e_mis, input logic e_to,
                          input logic [31:0] e_rd, input int e_req, input int e_lat);
    bus_t  b;
    done_t d;
    @(negedge clock);
    ack_delay = k;
    rdata_cfg = rdat;
    if (has_bus) begin
      b = '{wr, e_addr, e_be, e_wd};
      exp_bus.push_back(b);
    end
    if (has_done) begin
      d = '{e_mis, e_to, e_rd, e_req, e_lat, cyc};
      exp_done.push_back(d);
    end
    start = 1'b1; mem_read = rd; mem_write = wr; size = sz;
    load_unsigned = uns; address = addr; write_data = wd;
    @(negedge clock);
    start = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    #1;
    while (exp_done.size() != 0 && n < 40) begin
      @(negedge clock);
      #1;
      n++;
    end
    if (exp_done.size() != 0) begin
      fail("done_wait", "got no done within 40 cycles, required done");
      exp_done.delete();
    end
    @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc;
    repeat (3) @(negedge clock);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_flags", {30'd0, misaligned, timeout}, 32'd0);
    check("rst_dm_req_we", {30'd0, dm_req, dm_we}, 32'd0);
    check("rst_dm_addr", dm_addr, 32'd0);
    check("rst_dm_wdata", dm_wdata, 32'd0);
    check("rst_dm_be", 32'(dm_be), 32'd0);
    check("rst_read_data", read_data, 32'd0);
    reset = 1'b0;

    //        rd wr sz    uns addr      wdata     k   rdata
    //        bus addr      be     wdata      done mis to rd         req lat
    start_op(1, 0, 2'b10, 0, 32'h100, 32'h0, 3, 32'hDEADBEEF,
             1, 32'h100, 4'hF, 32'h0, 1, 0, 0, 32'hDEADBEEF, 4, 5);
    wait_idle();
    start_op(1, 0, 2'b00, 0, 32'h103, 32'h0, 0, 32'h80FF1234,
             1, 32'h100, 4'h8, 32'h0, 1, 0, 0, 32'hFFFFFF80, 1, 2);
    wait_idle();
    start_op(1, 0, 2'b00, 1, 32'h103, 32'h0, 1, 32'h80FF1234,
             1, 32'h100, 4'h8, 32'h0, 1, 0, 0, 32'h00000080, 2, 3);
    wait_idle();
    start_op(0, 1, 2'b01, 0, 32'h42, 32'h1234ABCD, 2, 32'h0,
             1, 32'h40, 4'hC, 32'hABCDABCD, 1, 0, 0, 32'h00000080, 3, 4);
    wait_idle();
    start_op(0, 1, 2'b00, 0, 32'h41, 32'h1234ABCD, 0, 32'h0,
             1, 32'h40, 4'h2, 32'hCDCDCDCD, 1, 0, 0, 32'h00000080, 1, 2);
    wait_idle();
    start_op(1, 0, 2'b10, 0, 32'h102, 32'h0, 0, 32'h0,
             0, 32'h0, 4'h0, 32'h0, 1, 1, 0, 32'h00000080, 0, 1);
    wait_idle();
    start_op(1, 0, 2'b01, 0, 32'h202, 32'h0, 1, 32'h80017FFF,
             1, 32'h200, 4'hC, 32'h0, 1, 0, 0, 32'hFFFF8001, 2, 3);
    wait_idle();
    start_op(1, 0, 2'b01, 1, 32'h200, 32'h0, 0, 32'h7FFF8001,
             1, 32'h200, 4'h3, 32'h0, 1, 0, 0, 32'h00008001, 1, 2);
    wait_idle();
    start_op(1, 0, 2'b10, 0, 32'h204, 32'h0, -1, 32'h0,
             1, 32'h204, 4'hF, 32'h0, 1, 0, 1, 32'h00008001, 4, 5);
    wait_idle();
    start_op(0, 0, 2'b10, 0, 32'h208, 32'h0, 0, 32'h0,
             0, 32'h0, 4'h0, 32'h0, 1, 0, 0, 32'h00008001, 0, 1);
    wait_idle();
    start_op(0, 1, 2'b11, 0, 32'h300, 32'h89ABCDEF, 0, 32'h0,
             1, 32'h300, 4'hF, 32'h89ABCDEF, 1, 0, 0, 32'h00008001, 1, 2);
    wait_idle();
    start_op(0, 1, 2'b01, 0, 32'h101, 32'h0, 0, 32'h0,
             0, 32'h0, 4'h0, 32'h0, 1, 1, 0, 32'h00008001, 0, 1);
    wait_idle();
    start_op(1, 1, 2'b00, 0, 32'h2, 32'h55, 0, 32'hFFFFFFFF,
             1, 32'h0, 4'h4, 32'h55555555, 1, 0, 0, 32'h00008001, 1, 2);
    wait_idle();
    start_op(1, 0, 2'b00, 0, 32'h1, 32'h0, 0, 32'h1234C856,
             1, 32'h0, 4'h2, 32'h0, 1, 0, 0, 32'hFFFFFFC8, 1, 2);
    wait_idle();

    // Acks while idle must do nothing.
    dc = done_count;
    stray_ack = 1'b1;
    repeat (3) @(negedge clock);
    stray_ack = 1'b0;
    @(negedge clock);
    check("stray_ack_done", 32'(done_count - dc), 32'd0);
    check("stray_ack_busy", 32'(busy), 32'd0);

    // Reset in the middle of an access drops it silently.
    start_op(1, 0, 2'b10, 0, 32'h400, 32'h0, -1, 32'h0,
             1, 32'h400, 4'hF, 32'h0, 0, 0, 0, 32'h0, 0, 0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("midrst_dm_req", 32'(dm_req), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_read_data", read_data, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    dc = done_count;
    repeat (8) @(negedge clock);
    check("midrst_no_done", 32'(done_count - dc), 32'd0);

    // A start pulsed while busy is ignored.
    start_op(1, 0, 2'b10, 0, 32'h500, 32'h0, 2, 32'hCAFEF00D,
             1, 32'h500, 4'hF, 32'h0, 1, 0, 0, 32'hCAFEF00D, 3, 4);
    dc = done_count;
    start = 1'b1; mem_read = 1'b1; size = 2'b10; address = 32'h503;
    @(negedge clock);
    start = 1'b0; mem_read = 1'b0;
    wait_idle();
    repeat (4) @(negedge clock);
    check("busy_start_one_done", 32'(done_count - dc), 32'd1);
    check("bus_queue_empty", 32'(exp_bus.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
Memory-access stage of the multicycle MIPS datapath. Sits directly downstream of the execute stage: consumes the ALU result as the effective address and register-file read data 2 as store data. Runs byte, halfword and word loads and stores against a data memory with variable latency over a req/ack handshake, and stalls the controller while the access is in flight. Returns sign- or zero-extended load data to the write-back path.

Parameters:
WAIT_LIMIT, 64, maximum number of cycles spent in REQ before the access is abandoned with timeout; legal range 2..65535.

Ports:
clock  input  1  system clock, rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  one-cycle request to begin an operation; sampled only in IDLE.
mem_read  input  1  operation is a load.
mem_write  input  1  operation is a store; wins over mem_read if both are high.
size  input  2  access size: 00 byte, 01 half, 10 word; 11 is treated as word.
load_unsigned  input  1  1 = zero-extend load data, 0 = sign-extend it.
address  input  32  effective address (ALU result).
write_data  input  32  store data (register read data 2).
busy  output  1  high in every state except IDLE.
done  output  1  one-cycle completion pulse.
read_data  output  32  formatted load result; held until the next load completes.
misaligned  output  1  pulses together with done when an address is rejected.
timeout  output  1  pulses together with done when the access is abandoned.
dm_req  output  1  data-memory request.
dm_we  output  1  data-memory write enable.
dm_addr  output  32  word-aligned address, {address[31:2],2'b00}.
dm_wdata  output  32  lane-replicated store data.
dm_be  output  4  byte enables; bit i enables bits 8i+7..8i.
dm_rdata  input  32  data-memory read data; valid in the dm_ack cycle.
dm_ack  input  1  data-memory acknowledge.

Behaviour:
- Reset (synchronous, takes effect at the edge): state=IDLE; busy, done, misaligned, timeout, dm_req, dm_we = 0; dm_addr, dm_wdata, read_data = 0; dm_be = 0000; wait counter = 0. A reset asserted mid-access drops dm_req at that edge; the access is lost and no done pulse is produced.
- All outputs are registered. Byte lanes are little-endian: lane = address[1:0].
- FSM states: IDLE, REQ, FIN.
- IDLE, start=0: remain in IDLE.
- IDLE, start=1, neither mem_read nor mem_write: go to FIN. Produces done with no memory traffic; read_data unchanged.
- IDLE, start=1, access with a misaligned address (half with address[0]=1, or word with address[1:0]!=00): go to FIN with misaligned=1. dm_req is never raised.
- IDLE, start=1, aligned access: latch the operation into registers and go to REQ. In that same edge, drive dm_req=1, dm_we, dm_addr, dm_wdata and dm_be.
  - Byte: dm_be = 0001 shifted left by address[1:0]; dm_wdata = write_data[7:0] replicated into all four lanes.
  - Half: dm_be = 0011 if address[1]=0, else 1100; dm_wdata = {write_data[15:0], write_data[15:0]}.
  - Word: dm_be = 1111; dm_wdata = write_data.
  - Loads drive dm_be the same way; memory may ignore it.
- REQ: dm_req and all dm_* outputs are held stable.
  - dm_ack=1: drop dm_req and go to FIN. For a load, in the same edge read_data takes the selected lane of dm_rdata, extended per load_unsigned.
  - dm_ack=0: the counter increments. If it reaches WAIT_LIMIT-1 with no ack, drop dm_req and go to FIN with timeout=1.
  - dm_ack and the limit in the same cycle: ack wins and timeout stays 0.
  - The counter clears on entry to REQ.
- FIN: done=1 for exactly one cycle, along with misaligned/timeout as flagged; next state is IDLE, where done, misaligned and timeout return to 0.
- busy=1 in REQ and FIN. A start received while busy is ignored.
- Latency: with start at edge 0 and dm_ack sampled k cycles after dm_req rises (k>=0), done is high in cycle k+2. A rejected or no-op operation has done high in cycle 1.
- dm_ack outside REQ is ignored.

Test Plan:
- Word load: reset, start with mem_read, size=10, address=0x100; ack after 3 cycles with dm_rdata=0xDEADBEEF -> dm_addr=0x100, dm_be=1111, done 1 cycle, read_data=0xDEADBEEF, busy=1 for 5 cycles.
- Signed and unsigned byte load: address=0x103, dm_rdata=0x80FF1234 -> dm_be=1000. load_unsigned=0 gives read_data=0xFFFFFF80; load_unsigned=1 gives 0x00000080.
- Half and byte store: size=01, address=0x42, write_data=0x1234ABCD -> dm_we=1, dm_addr=0x40, dm_be=1100, dm_wdata=0xABCDABCD. Byte store at 0x41 -> dm_be=0010, dm_wdata=0xCDCDCDCD.
- Misaligned: word load at 0x102 -> dm_req never rises, done=1 and misaligned=1 in cycle 1, read_data unchanged.
- Timeout: WAIT_LIMIT=4, no ack -> dm_req high exactly 4 cycles, then done=1 with timeout=1. With dm_ack in the 4th REQ cycle instead -> done=1, timeout=0.
- Reset mid-access and start while busy: assert reset in REQ -> dm_req=0 and busy=0 after the edge, no done pulse. A start pulsed during REQ is ignored and produces exactly one done.
